vga_pixel_timing: RTL
=====================

Name: vga_pixel_timing

Overview:
- Raster timing generator and output stage on the far side of the object-priority mux.
- Drives pixelX/pixelY to every drawing object.
- Takes back the mux's registered 8-bit RRRGGGBB colour, expands it to 4:4:4 and drives the VGA DAC.
- Aligns hsync, vsync and blanking with the mux pipeline latency, and gives game logic a one-cycle end-of-frame tick.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch
- PIPE_DELAY, 1, clk cycles from pixelX/pixelY change to the matching RGBIn; legal range 0..4

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal); the only clock
- resetN  in  1  synchronous active-low reset
- RGBIn  in  8  colour from the object mux, {R[2:0],G[2:0],B[1:0]}
- pixelX  out  11  current horizontal counter, 0..H_TOTAL-1
- pixelY  out  11  current vertical counter, 0..V_TOTAL-1
- startOfFrame  out  1  one-cycle pulse while counters = (0,0)
- endOfFrame  out  1  one-cycle pulse while counters = (H_TOTAL-1, V_TOTAL-1)
- red  out  4  DAC red
- green  out  4  DAC green
- blue  out  4  DAC blue
- h_sync  out  1  active-low hsync
- v_sync  out  1  active-low vsync
- blank_n  out  1  high when the DAC pixel is visible

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800 at defaults); V_TOTAL = sum of the V_* parameters (525 at defaults).
- Counters hc, vc are registered.
  - hc increments every clk and wraps H_TOTAL-1 -> 0.
  - vc increments only on an hc wrap, and wraps V_TOTAL-1 -> 0 when both counters are at their maximum.
- pixelX = hc, pixelY = vc, both driven directly from the registers.
- Raw, undelayed signals:
  - act = (hc < H_ACTIVE) && (vc < V_ACTIVE)
  - hs = !((hc >= H_ACTIVE+H_FP) && (hc < H_ACTIVE+H_FP+H_SYNC))
  - vs = !((vc >= V_ACTIVE+V_FP) && (vc < V_ACTIVE+V_FP+V_SYNC))
  - vsync is line-based: asserted for whole lines, changing only at hc = 0.
- Delay line: {act, hs, vs} passes through a PIPE_DELAY-deep shift register (PIPE_DELAY = 0 means pass-through), so it lines up with RGBIn.
- Output register, updated every clk:
  - h_sync, v_sync and blank_n take the delayed values.
  - If delayed act = 1:
    - red = {RGBIn[7:5], RGBIn[7]}
    - green = {RGBIn[4:2], RGBIn[4]}
    - blue = {RGBIn[1:0], RGBIn[1:0]}
  - Otherwise red, green and blue are 0. The DAC must see black in blanking whatever the mux outputs.
- Total latency: counter value C on pixelX/pixelY at cycle n appears as sync/blank/colour at cycle n+PIPE_DELAY+1.
- startOfFrame and endOfFrame are combinational decodes of the counter registers. They are undelayed and aligned with pixelX/pixelY, not with the DAC.
- Reset, sampled on posedge clk while resetN = 0:
  - hc = vc = 0.
  - All delay stages set to act = 0, hs = 1, vs = 1.
  - red/green/blue = 0, h_sync = 1, v_sync = 1, blank_n = 0.
  - startOfFrame and endOfFrame follow the counters, so startOfFrame = 1 during reset (counters at 0,0) and endOfFrame = 0.
- Reset mid-frame:
  - Counters return to (0,0) at the first edge with resetN = 0.
  - The first visible pixel after release is (0,0), with the normal latency.
  - No partial sync pulse or stale colour may leak out of the delay line.
- Wrap at (H_TOTAL-1, V_TOTAL-1): the next cycle is (0,0). No skipped or duplicated line.

Test Plan:
- Reset and idle at defaults:
  - Hold resetN = 0 for 5 cycles with RGBIn = FF -> red/green/blue = 0, h_sync = 1, v_sync = 1, blank_n = 0, pixelX = pixelY = 0.
  - Release -> pixelX counts 0,1,2,... one per clk.
- Horizontal timing: counters hold each value k for one clk after release -> h_sync goes low 658 cycles after release (656+PIPE_DELAY+1), stays low exactly 96 cycles, and repeats every 800 cycles.
- Frame timing:
  - endOfFrame pulses once every 420000 cycles, while pixelX = 799 and pixelY = 524.
  - startOfFrame pulses on the next cycle.
  - v_sync is low for exactly 1600 cycles (2 lines), starting 2 cycles after (hc,vc) = (0,490).
- Colour expansion: drive RGBIn one cycle after pixelX to emulate a PIPE_DELAY = 1 mux.
  - RGBIn = E0 at active pixel (10,10) -> red = F, green = 0, blue = 0.
  - RGBIn = 01110110 -> red = 6, green = B, blue = A.
- Blanking override: RGBIn = FF throughout the whole frame -> colours = FFF only where blank_n = 1; exactly 640 consecutive blank_n = 1 cycles per visible line; zeros elsewhere.
- Reset mid-frame: assert resetN = 0 for 1 cycle at (300,200) ->
  - Next cycle pixelX = 0, pixelY = 0.
  - blank_n = 0 and colours = 0 for the next 2 cycles.
  - Then normal frame timing from (0,0). Repeat the timing checks with PIPE_DELAY = 0 and PIPE_DELAY = 3 (latency 1 and 4).

Source files
------------

// File: rtl/vga_pixel_timing_if.sv
// Pixel-side bundle of the VGA timing block: object-mux colour in, raster
// coordinates, frame ticks and the DAC/sync outputs.
interface vga_pixel_timing_if;
  logic [7:0]  RGBIn;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        endOfFrame;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        h_sync;
  logic        v_sync;
  logic        blank_n;

  modport master (
    input  RGBIn,
    output pixelX, pixelY,
    output startOfFrame, endOfFrame,
    output red, green, blue,
    output h_sync, v_sync, blank_n
  );

  modport slave (
    output RGBIn,
    input  pixelX, pixelY,
    input  startOfFrame, endOfFrame,
    input  red, green, blue,
    input  h_sync, v_sync, blank_n
  );
endinterface

// File: rtl/vga_pixel_timing.sv
// VGA raster counters, sync/blank delay line matched to the object mux, and
// RRRGGGBB -> 4:4:4 DAC output stage. Ports: clk, resetN (sync, low), bus.
module vga_pixel_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic clk,
  input  logic resetN,
  vga_pixel_timing_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_MAX = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] HS_LO = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_LO = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_HI = 11'(V_ACTIVE + V_FP + V_SYNC);

  // {act, hs, vs} while idle: blanked, syncs inactive
  localparam logic [2:0] IDLE = 3'b011;

  logic [10:0] hc;
  logic [10:0] vc;
  logic        act;
  logic        hs;
  logic        vs;
  logic [2:0]  raw;
  logic [2:0]  dly;

  logic [3:0]  red_q;
  logic [3:0]  green_q;
  logic [3:0]  blue_q;
  logic        h_sync_q;
  logic        v_sync_q;
  logic        blank_n_q;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_MAX) begin
      hc <= '0;
      vc <= (vc == V_MAX) ? '0 : vc + 11'd1;
    end else begin
      hc <= hc + 11'd1;
    end
  end

  assign act = (hc < H_ACT) && (vc < V_ACT);
  assign hs  = !((hc >= HS_LO) && (hc < HS_HI));
  // vc only moves at hc = 0, so vsync spans whole lines
  assign vs  = !((vc >= VS_LO) && (vc < VS_HI));
  assign raw = {act, hs, vs};

  generate
    if (PIPE_DELAY == 0) begin : g_thru
      assign dly = raw;
    end else begin : g_pipe
      logic [2:0] sr [PIPE_DELAY];

      // reset flushes the line so no stale sync or visible flag survives
      always_ff @(posedge clk) begin
        if (!resetN) begin
          for (int i = 0; i < PIPE_DELAY; i++)
            sr[i] <= IDLE;
        end else begin
          sr[0] <= raw;
          for (int i = 1; i < PIPE_DELAY; i++)
            sr[i] <= sr[i-1];
        end
      end

      assign dly = sr[PIPE_DELAY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetN) begin
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      h_sync_q  <= 1'b1;
      v_sync_q  <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      h_sync_q  <= dly[1];
      v_sync_q  <= dly[0];
      blank_n_q <= dly[2];
      // MSB replication maps full-scale 3/2-bit codes to full-scale 4-bit
      if (dly[2]) begin
        red_q   <= {bus.RGBIn[7:5], bus.RGBIn[7]};
        green_q <= {bus.RGBIn[4:2], bus.RGBIn[4]};
        blue_q  <= {bus.RGBIn[1:0], bus.RGBIn[1:0]};
      end else begin
        red_q   <= '0;
        green_q <= '0;
        blue_q  <= '0;
      end
    end
  end

  assign bus.pixelX       = hc;
  assign bus.pixelY       = vc;
  assign bus.startOfFrame = (hc == '0) && (vc == '0);
  assign bus.endOfFrame   = (hc == H_MAX) && (vc == V_MAX);
  assign bus.red          = red_q;
  assign bus.green        = green_q;
  assign bus.blue         = blue_q;
  assign bus.h_sync       = h_sync_q;
  assign bus.v_sync       = v_sync_q;
  assign bus.blank_n      = blank_n_q;

endmodule
